multicycle_core: RTL and testbench

Parametrised successor to the 4-register, 8-bit-instruction multicycle CPU core. It runs the same ISA through FETCH/DECODE/EXECUTE/WRITEBACK, with configurable data width and memory depth. It adds a defined reset, an explicit start/halt handshake, a host program-load port and debug read ports. It sits below the board top, which drives `clk` from the divided 12 MHz clock and shows `pc` on the LEDs.

---
 rtl/multicycle_core.sv | 144 ++++++++++++++
 tb/tb_multicycle_core.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
// multicycle_core: four-register multicycle CPU (FETCH/DECODE/EXECUTE/WRITEBACK) with host loader and debug ports.
// Define CORE_SINGLE_STEP_EN to make each FETCH wait for the step input.
module multicycle_core #(
    parameter int DATA_W   = 8,
    parameter int MEM_AW   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              halted,
    output logic [MEM_AW-1:0] pc,
    input  logic              ld_we,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [MEM_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic [1:0]        dbg_reg_sel,
    output logic [DATA_W-1:0] dbg_reg_data,
    input  logic              step
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      mem_q [2**MEM_AW];
    logic [3:0][DATA_W-1:0] regs_q;
    logic [MEM_AW-1:0]      pc_q;
    logic [7:0]             ir_q;
    logic [DATA_W-1:0]      opa_q, opb_q, res_q, res_d;
    logic                   br_q, br_d;
    logic                   rd_en;
    logic [1:0]             rd_sel, opa_idx;
    logic                   is_halt, is_store, fetch_go;

`ifdef CORE_SINGLE_STEP_EN
    assign fetch_go = step;
`else
    logic unused_step;
    assign unused_step = step;
    assign fetch_go    = 1'b1;
`endif

    assign is_halt  = (ir_q == 8'h70);
    assign is_store = (ir_q[7:4] == 4'b0011);
    // LUI/LLI name their register in bits [5:4]; everything else uses rd in [3:2]
    assign opa_idx  = ir_q[7] ? ir_q[5:4] : ir_q[3:2];

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        halted  = 1'b0;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  begin busy = 1'b1; if (fetch_go) state_d = S_DECODE; end
            S_DECODE: begin busy = 1'b1; state_d = S_EXEC; end
            S_EXEC:   begin busy = 1'b1; state_d = is_halt ? S_HALT : S_WB; end
            S_WB:     begin busy = 1'b1; state_d = S_FETCH; end
            S_HALT:   begin halted = 1'b1; if (start) state_d = S_FETCH; end
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        res_d  = opa_q;
        br_d   = 1'b0;
        rd_en  = 1'b0;
        rd_sel = ir_q[3:2];
        casez (ir_q)
            8'b0000_????: begin res_d = opa_q + opb_q; rd_en = 1'b1; end
            8'b0001_????: begin res_d = opa_q - opb_q; rd_en = 1'b1; end
            8'b0010_????: begin res_d = mem_q[opb_q[MEM_AW-1:0]]; rd_en = 1'b1; end
            8'b0100_????: br_d = (opb_q == '0);
            8'b0101_????: begin
                // link value is the already-incremented pc; target is rd as read in DECODE
                res_d  = DATA_W'(pc_q);
                rd_en  = 1'b1;
                rd_sel = ir_q[1:0];
                br_d   = 1'b1;
            end
            8'b10??_????: begin
                res_d      = '0;
                res_d[7:0] = {ir_q[3:0], opa_q[3:0]};
                rd_en      = 1'b1;
                rd_sel     = ir_q[5:4];
            end
            8'b11??_????: begin
                res_d  = {opa_q[DATA_W-1:4], ir_q[3:0]};
                rd_en  = 1'b1;
                rd_sel = ir_q[5:4];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= MEM_AW'(RESET_PC);
            regs_q <= '0;
            ir_q   <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            res_q  <= '0;
            br_q   <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: if (fetch_go) begin
                    ir_q <= mem_q[pc_q][7:0];
                    pc_q <= pc_q + MEM_AW'(1);
                end
                S_DECODE: begin
                    opa_q <= regs_q[opa_idx];
                    opb_q <= regs_q[ir_q[1:0]];
                end
                S_EXEC: begin
                    res_q <= res_d;
                    br_q  <= br_d;
                end
                S_WB: begin
                    if (rd_en) regs_q[rd_sel] <= res_q;
                    if (br_q)  pc_q <= opa_q[MEM_AW-1:0];
                end
                default: ;
            endcase
        end
    end

    // Memory has no reset; a reset edge only suppresses the write on that edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_EXEC && is_store) mem_q[opb_q[MEM_AW-1:0]] <= opa_q;
            else if (ld_we && !busy)           mem_q[ld_addr] <= ld_data;
        end
    end

    assign pc           = pc_q;
    assign dbg_data     = mem_q[dbg_addr];
    assign dbg_reg_data = regs_q[dbg_reg_sel];
endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: directed programs on an 8-bit core and a 16-bit/16-word core, checked by a scoreboard monitor.
`timescale 1ns/100ps
module tb_multicycle_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    logic        start8 = 0, ld_we8 = 0, busy8, halted8;
    logic [7:0]  ld_addr8 = 0, ld_data8 = 0, dbg_addr8 = 0, pc8, dbg_data8, dbg_reg8;
    logic [1:0]  dbg_sel8 = 0;
    logic        start16 = 0, ld_we16 = 0, busy16, halted16;
    logic [3:0]  ld_addr16 = 0, dbg_addr16 = 0, pc16;
    logic [15:0] ld_data16 = 0, dbg_data16, dbg_reg16;
    logic [1:0]  dbg_sel16 = 0;
    logic        step = 1'b0;

    multicycle_core dut8 (
        .clk(clk), .rst(rst), .start(start8), .busy(busy8), .halted(halted8), .pc(pc8),
        .ld_we(ld_we8), .ld_addr(ld_addr8), .ld_data(ld_data8),
        .dbg_addr(dbg_addr8), .dbg_data(dbg_data8), .dbg_reg_sel(dbg_sel8),
        .dbg_reg_data(dbg_reg8), .step(step)
    );

    multicycle_core #(.DATA_W(16), .MEM_AW(4), .RESET_PC(1)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .busy(busy16), .halted(halted16), .pc(pc16),
        .ld_we(ld_we16), .ld_addr(ld_addr16), .ld_data(ld_data16),
        .dbg_addr(dbg_addr16), .dbg_data(dbg_data16), .dbg_reg_sel(dbg_sel16),
        .dbg_reg_data(dbg_reg16), .step(step)
    );

    typedef struct packed {
        logic [7:0]       id;
        logic             dut;   // 0: 8-bit core, 1: 16-bit core
        logic             halt;
        logic [7:0]       lat;   // clocks from start edge to busy falling; 0 = not checked
        logic [7:0]       pc;
        logic [3:0][15:0] r;
        logic             mchk;
        logic [7:0]       maddr;
        logic [15:0]      mval;
        logic [31:0]      scyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0, passed = 0, total = 0, done_cnt = 0, pushed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        else passed++;
    endtask

    function automatic exp_t mk(input logic [7:0] id, input logic d, input logic h,
                                input logic [7:0] lat, input logic [7:0] pcv,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] dd,
                                input logic mc, input logic [7:0] ma, input logic [15:0] mv);
        exp_t e;
        e = '0;
        e.id = id; e.dut = d; e.halt = h; e.lat = lat; e.pc = pcv;
        e.r[0] = a; e.r[1] = b; e.r[2] = c; e.r[3] = dd;
        e.mchk = mc; e.maddr = ma; e.mval = mv;
        return e;
    endfunction

    // Monitor: a falling busy is the core's "result ready" event (halt or reset abort).
    initial begin
        logic b8p, b16p, ev;
        exp_t e;
        b8p = 0; b16p = 0;
        forever begin
            @(negedge clk);
            if ((b8p && !busy8) || (b16p && !busy16)) begin
                ev = b16p && !busy16;
                if (sb.size() == 0) begin
                    chk("unexpected_event", 32'(ev), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("run%0d dut", e.id), 32'(ev), 32'(e.dut));
                    chk($sformatf("run%0d halted", e.id), 32'(ev ? halted16 : halted8), 32'(e.halt));
                    if (e.lat != 0)
                        chk($sformatf("run%0d latency", e.id), 32'(cyc) - e.scyc, 32'(e.lat));
                    chk($sformatf("run%0d pc", e.id), ev ? 32'(pc16) : 32'(pc8), 32'(e.pc));
                    for (int i = 0; i < 4; i++) begin
                        dbg_sel8 = i[1:0]; dbg_sel16 = i[1:0];
                        #1;
                        chk($sformatf("run%0d reg%0d", e.id, i),
                            ev ? 32'(dbg_reg16) : 32'(dbg_reg8), 32'(e.r[i]));
                    end
                    if (e.mchk) begin
                        dbg_addr8 = e.maddr; dbg_addr16 = e.maddr[3:0];
                        #1;
                        chk($sformatf("run%0d mem[%0h]", e.id, e.maddr),
                            ev ? 32'(dbg_data16) : 32'(dbg_data8), 32'(e.mval));
                    end
                end
                done_cnt++;
            end
            b8p = busy8; b16p = busy16;
        end
    end

    // All stimulus tasks start and end at 1 ns after a rising edge.
    task automatic do_rst();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic ld8(input logic [7:0] a, input logic [7:0] d);
        ld_we8 = 1; ld_addr8 = a; ld_data8 = d;
        @(posedge clk); #1;
        ld_we8 = 0;
    endtask

    task automatic ld16(input logic [3:0] a, input logic [15:0] d);
        ld_we16 = 1; ld_addr16 = a; ld_data16 = d;
        @(posedge clk); #1;
        ld_we16 = 0;
    endtask

    task automatic prog8(input logic [7:0] base, input logic [7:0] p[]);
        foreach (p[i]) ld8(base + 8'(i), p[i]);
    endtask

    task automatic go(input exp_t e);
        if (e.dut) start16 = 1; else start8 = 1;
        @(posedge clk); #1;
        start8 = 0; start16 = 0; ld_we8 = 0; ld_we16 = 0;
        e.scyc = 32'(cyc);
        sb.push_back(e);
        pushed++;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt < pushed && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (done_cnt < pushed) begin
            chk("timeout", 32'(done_cnt), 32'(pushed));
            sb.delete();
            done_cnt = pushed;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // main program: LLI/ADD/LUI/STORE/HALT
        do_rst(); ld8(8'hF0, 8'h00);
        prog8(0, '{8'hC5, 8'hD3, 8'h01, 8'hAF, 8'h32, 8'h70});
        go(mk(1, 0, 1, 23, 6, 16'h08, 16'h03, 16'hF0, 16'h00, 1, 8'hF0, 16'h08));
        wait_done(100);

        // BZ taken (A == 0) skips F1
        do_rst();
        prog8(0, '{8'hD6, 8'h44, 8'hF1, 8'h60, 8'h60, 8'h60, 8'h70});
        go(mk(2, 0, 1, 11, 7, 16'h00, 16'h06, 16'h00, 16'h00, 0, 0, 0));
        wait_done(100);

        // BZ falls through with A = 1
        do_rst();
        prog8(0, '{8'hC1, 8'hD6, 8'h44, 8'hF1, 8'h60, 8'h60, 8'h70});
        go(mk(3, 0, 1, 27, 7, 16'h01, 16'h06, 16'h00, 16'h01, 0, 0, 0));
        wait_done(100);

        // JAL B, C
        do_rst();
        prog8(0, '{8'hD4, 8'h56, 8'hF1, 8'hF1, 8'h70});
        go(mk(4, 0, 1, 11, 5, 16'h00, 16'h04, 16'h02, 16'h00, 0, 0, 0));
        wait_done(100);

        // JAL with rd == rs: link to B, jump to old B
        do_rst(); ld8(1, 8'h55);
        go(mk(5, 0, 1, 11, 5, 16'h00, 16'h02, 16'h00, 16'h00, 0, 0, 0));
        wait_done(100);

        // SUB wraps 0 - 1
        do_rst();
        prog8(0, '{8'hD1, 8'h11, 8'h70});
        go(mk(6, 0, 1, 11, 3, 16'hFF, 16'h01, 16'h00, 16'h00, 0, 0, 0));
        wait_done(100);

        // STORE then LOAD from the same address
        do_rst(); ld8(8'hE0, 8'h55);
        prog8(0, '{8'hC9, 8'hAE, 8'h32, 8'h2E, 8'h70});
        go(mk(7, 0, 1, 19, 5, 16'h09, 16'h00, 16'hE0, 16'h09, 1, 8'hE0, 16'h09));
        wait_done(100);

        // resume from HALT at the following address
        prog8(5, '{8'hC3, 8'h70});
        go(mk(8, 0, 1, 7, 7, 16'h03, 16'h00, 16'hE0, 16'h09, 1, 8'hE0, 16'h09));
        wait_done(100);

        // host write while busy is dropped
        do_rst(); ld8(8'h80, 8'h11);
        prog8(0, '{8'h60, 8'h60, 8'h60, 8'h70});
        go(mk(9, 0, 1, 15, 4, 16'h00, 16'h00, 16'h00, 16'h00, 1, 8'h80, 16'h11));
        ld8(8'h80, 8'hEE);
        wait_done(100);

        // host write in the start cycle is seen by the first FETCH
        do_rst();
        prog8(0, '{8'h70, 8'h70});
        ld_we8 = 1; ld_addr8 = 8'h00; ld_data8 = 8'hC7;
        go(mk(10, 0, 1, 7, 2, 16'h07, 16'h00, 16'h00, 16'h00, 0, 0, 0));
        wait_done(100);

        // reset during the EXECUTE of STORE: no store, state cleared
        do_rst(); ld8(8'hD0, 8'h44);
        prog8(0, '{8'hC9, 8'hAD, 8'h32, 8'h70});
        go(mk(11, 0, 0, 0, 0, 16'h00, 16'h00, 16'h00, 16'h00, 1, 8'hD0, 16'h44));
        repeat (10) @(posedge clk);
        #1;
        do_rst();
        wait_done(100);

        // 16-bit core (RESET_PC = 1): LUI clears upper bits
        do_rst(); ld16(4'hF, 16'h1234);
        ld16(1, 16'h00DF); ld16(2, 16'h0021); ld16(3, 16'h0085); ld16(4, 16'h0070);
        go(mk(12, 1, 1, 15, 5, 16'h0054, 16'h000F, 16'h0000, 16'h0000, 1, 8'h0F, 16'h1234));
        wait_done(100);

        // LLI keeps upper bits
        do_rst(); ld16(3, 16'h00C7);
        go(mk(13, 1, 1, 15, 5, 16'h1237, 16'h000F, 16'h0000, 16'h0000, 0, 0, 0));
        wait_done(100);

        // pc wraps 15 -> 0 and reaches the HALT at address 0
        do_rst();
        for (int i = 1; i < 16; i++) ld16(4'(i), 16'h0060);
        ld16(0, 16'h0070);
        go(mk(14, 1, 1, 63, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 8'h00, 16'h0070));
        wait_done(150);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
